// File: rtl/mem_arbiter.sv
// Purpose: shares one data-memory port between the CPU load/store master and the DMA master.
// Latency: grant is registered, so mem_req rises 1 cycle after a request is first seen; the ready/rdata return is combinational.
// Backpressure: each requester holds req until its ready; the loser simply waits, and nothing is buffered or reordered.
//
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   cpu_req/we/addr/wdata -> cpu_ready/rdata   CPU request group and completion
//   dma_req/we/addr/wdata -> dma_ready/rdata   DMA request group and completion
//   mem_req/we/addr/wdata <- mem_ready/rdata   shared memory port
//   arb_owner                           registered owner: 00 none, 01 CPU, 10 DMA
//   dma_stall_cnt                       DMA stall statistic
//
// Optional feature: define MEM_ARB_STATS_EN to build the 32-bit saturating DMA stall counter.
// Without it, dma_stall_cnt is tied to zero and no counter flops are built.

module mem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int XLEN     = 32,
    parameter int MAX_WAIT = 16
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [XLEN-1:0]   cpu_wdata,
    output logic              cpu_ready,
    output logic [XLEN-1:0]   cpu_rdata,

    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [XLEN-1:0]   dma_wdata,
    output logic              dma_ready,
    output logic [XLEN-1:0]   dma_rdata,

    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_ready,
    input  logic [XLEN-1:0]   mem_rdata,

    output logic [1:0]        arb_owner,
    output logic [31:0]       dma_stall_cnt
);

    // Grant states share their encoding with arb_owner; GAP is masked to 00.
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GNT_CPU = 2'b01,
        GNT_DMA = 2'b10,
        GAP     = 2'b11
    } state_t;

    state_t     state;
    state_t     next_state;
    logic [7:0] wait_cnt;
    logic       dma_starved;
    logic       dma_wins;
    logic       dma_waiting;

    // Starvation guard: once DMA has waited MAX_WAIT cycles it beats a pending CPU request.
    assign dma_starved = (MAX_WAIT != 0) && (int'(wait_cnt) >= MAX_WAIT);
    assign dma_wins    = dma_req && (!cpu_req || dma_starved);
    assign dma_waiting = dma_req && (state != GNT_DMA);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (dma_wins) begin
                    next_state = GNT_DMA;
                end else if (cpu_req) begin
                    next_state = GNT_CPU;
                end else begin
                    next_state = IDLE;
                end
            end
            GNT_CPU: begin
                // Dropping req before mem_ready aborts straight back to IDLE
                // and any mem_ready seen in that cycle is discarded.
                if (!cpu_req) begin
                    next_state = IDLE;
                end else if (mem_ready) begin
                    next_state = GAP;
                end
            end
            GNT_DMA: begin
                if (!dma_req) begin
                    next_state = IDLE;
                end else if (mem_ready) begin
                    next_state = GAP;
                end
            end
            GAP: begin
                // One bubble so the finished owner can drop its req before re-arbitration.
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        cpu_ready = 1'b0;
        cpu_rdata = '0;
        dma_ready = 1'b0;
        dma_rdata = '0;
        arb_owner = 2'b00;
        case (state)
            GNT_CPU: begin
                mem_req   = cpu_req;
                mem_we    = cpu_we;
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
                cpu_ready = cpu_req && mem_ready;
                cpu_rdata = mem_rdata;
                arb_owner = 2'b01;
            end
            GNT_DMA: begin
                mem_req   = dma_req;
                mem_we    = dma_we;
                mem_addr  = dma_addr;
                mem_wdata = dma_wdata;
                dma_ready = dma_req && mem_ready;
                dma_rdata = mem_rdata;
                arb_owner = 2'b10;
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // DMA wait counter (8-bit, saturating, cleared on entry to GNT_DMA)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= 8'd0;
        end else if ((state != GNT_DMA) && (next_state == GNT_DMA)) begin
            wait_cnt <= 8'd0;
        end else if (dma_waiting && (wait_cnt != 8'hFF)) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    // ------------------------------------------------------------------
    // DMA stall statistic
    // ------------------------------------------------------------------
`ifdef MEM_ARB_STATS_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= 32'd0;
        end else if (dma_waiting && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign dma_stall_cnt = stall_q;
`else
    assign dma_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        cpu_req, cpu_we, dma_req, dma_we, mem_ready;
    logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata, mem_rdata;

    logic        cpu_ready, dma_ready, mem_req, mem_we;
    logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, dma_stall_cnt;
    logic [1:0]  arb_owner;

    logic        w4_cpu_ready, w4_dma_ready, w4_mem_req, w4_mem_we;
    logic [31:0] w4_cpu_rdata, w4_dma_rdata, w4_mem_addr, w4_mem_wdata, w4_dma_stall_cnt;
    logic [1:0]  w4_arb_owner;

    int checks;
    int failures;

    logic [165:0] outs16;
    assign outs16 = {cpu_ready, cpu_rdata, dma_ready, dma_rdata, mem_req, mem_we,
                     mem_addr, mem_wdata, arb_owner, dma_stall_cnt};

    mem_arbiter #(.ADDR_W(32), .XLEN(32), .MAX_WAIT(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_ready(dma_ready), .dma_rdata(dma_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .arb_owner(arb_owner), .dma_stall_cnt(dma_stall_cnt)
    );

    mem_arbiter #(.ADDR_W(32), .XLEN(32), .MAX_WAIT(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(w4_cpu_ready), .cpu_rdata(w4_cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_ready(w4_dma_ready), .dma_rdata(w4_dma_rdata),
        .mem_req(w4_mem_req), .mem_we(w4_mem_we), .mem_addr(w4_mem_addr), .mem_wdata(w4_mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .arb_owner(w4_arb_owner), .dma_stall_cnt(w4_dma_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = 32'h0; dma_wdata = 32'h0;
        mem_ready = 1'b0; mem_rdata = 32'h0;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        idle_inputs();
        mem_ready = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (outs16 !== '0) begin
                failures++;
                $display("FAIL reset_hold cycle=%0d got=%h exp=0", i, outs16);
            end
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (outs16 !== '0 || arb_owner !== 2'b00) begin
                failures++;
                $display("FAIL reset_idle cycle=%0d got=%h exp=0", i, outs16);
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_cpu_read;
        do_reset();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h100; cpu_wdata = 32'h5555;
        mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b0 || arb_owner !== 2'b00) begin
            failures++;
            $display("FAIL cpu_rd_first_cycle got mem_req=%b owner=%b exp 0/00", mem_req, arb_owner);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (arb_owner !== 2'b01 || mem_req !== 1'b1 || mem_we !== 1'b0) begin
            failures++;
            $display("FAIL cpu_rd_grant got owner=%b req=%b we=%b exp 01/1/0", arb_owner, mem_req, mem_we);
        end
        checks++;
        if (mem_addr !== 32'h100 || mem_wdata !== 32'h5555) begin
            failures++;
            $display("FAIL cpu_rd_addr got addr=%h wdata=%h exp 100/5555", mem_addr, mem_wdata);
        end
        checks++;
        if (cpu_ready !== 1'b0) begin
            failures++;
            $display("FAIL cpu_rd_early_ready got=%b exp=0", cpu_ready);
        end
        next_cycle();
        mem_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (cpu_ready !== 1'b1 || cpu_rdata !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL cpu_rd_data got ready=%b rdata=%h exp 1/deadbeef", cpu_ready, cpu_rdata);
        end
        checks++;
        if (dma_ready !== 1'b0 || dma_rdata !== 32'h0) begin
            failures++;
            $display("FAIL cpu_rd_dma_quiet got ready=%b rdata=%h exp 0/0", dma_ready, dma_rdata);
        end
        next_cycle();
        cpu_req = 1'b0;
        @(negedge clk);
        checks++;
        if (cpu_ready !== 1'b0 || mem_req !== 1'b0 || arb_owner !== 2'b00) begin
            failures++;
            $display("FAIL cpu_rd_gap got ready=%b req=%b owner=%b exp 0/0/00", cpu_ready, mem_req, arb_owner);
        end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_same_cycle;
        do_reset();
        cpu_req = 1'b1; dma_req = 1'b1; dma_addr = 32'h300;
        next_cycle();
        mem_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (arb_owner !== 2'b01 || cpu_ready !== 1'b1 || dma_ready !== 1'b0) begin
            failures++;
            $display("FAIL same_cpu_first got owner=%b cpu_rdy=%b dma_rdy=%b exp 01/1/0", arb_owner, cpu_ready, dma_ready);
        end
        next_cycle();
        cpu_req = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (arb_owner !== 2'b00) begin
            failures++;
            $display("FAIL same_gap got owner=%b exp 00", arb_owner);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (arb_owner !== 2'b00 || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL same_idle got owner=%b req=%b exp 00/0", arb_owner, mem_req);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (arb_owner !== 2'b10 || mem_req !== 1'b1 || mem_addr !== 32'h300) begin
            failures++;
            $display("FAIL same_dma_next got owner=%b req=%b addr=%h exp 10/1/300", arb_owner, mem_req, mem_addr);
        end
        mem_ready = 1'b1;
        next_cycle();
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_dma_write;
        do_reset();
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h200; dma_wdata = 32'h1234_5678;
        cpu_addr = 32'hABC; mem_rdata = 32'hCAFE_F00D;
        next_cycle();
        @(negedge clk);
        checks++;
        if (arb_owner !== 2'b10 || mem_we !== 1'b1 || mem_addr !== 32'h200 || mem_wdata !== 32'h1234_5678) begin
            failures++;
            $display("FAIL dma_wr_bus got owner=%b we=%b addr=%h wdata=%h exp 10/1/200/12345678", arb_owner, mem_we, mem_addr, mem_wdata);
        end
        checks++;
        if (cpu_ready !== 1'b0) begin
            failures++;
            $display("FAIL dma_wr_cpu_quiet1 got=%b exp=0", cpu_ready);
        end
        next_cycle();
        mem_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (dma_ready !== 1'b1 || dma_rdata !== 32'hCAFE_F00D || mem_we !== 1'b1) begin
            failures++;
            $display("FAIL dma_wr_done got ready=%b rdata=%h we=%b exp 1/cafef00d/1", dma_ready, dma_rdata, mem_we);
        end
        checks++;
        if (cpu_ready !== 1'b0 || cpu_rdata !== 32'h0) begin
            failures++;
            $display("FAIL dma_wr_cpu_quiet2 got ready=%b rdata=%h exp 0/0", cpu_ready, cpu_rdata);
        end
        next_cycle();
        dma_req = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (arb_owner !== 2'b00 || cpu_ready !== 1'b0 || mem_we !== 1'b0) begin
            failures++;
            $display("FAIL dma_wr_gap got owner=%b cpu_rdy=%b we=%b exp 00/0/0", arb_owner, cpu_ready, mem_we);
        end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_abort;
        do_reset();
        cpu_req = 1'b1; cpu_addr = 32'h40;
        next_cycle();
        cpu_req = 1'b0; dma_req = 1'b1; mem_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b0 || cpu_ready !== 1'b0) begin
            failures++;
            $display("FAIL abort_drop got req=%b cpu_rdy=%b exp 0/0", mem_req, cpu_ready);
        end
        next_cycle();
        mem_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (arb_owner !== 2'b00) begin
            failures++;
            $display("FAIL abort_idle got owner=%b exp 00", arb_owner);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (arb_owner !== 2'b10) begin
            failures++;
            $display("FAIL abort_no_gap got owner=%b exp 10", arb_owner);
        end
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_starvation;
        do_reset();
        cpu_req = 1'b1; dma_req = 1'b1;
        next_cycle();                       // IDLE, wait_cnt 0 -> CPU
        mem_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (w4_arb_owner !== 2'b01 || w4_cpu_ready !== 1'b1) begin
            failures++;
            $display("FAIL starve_cpu1 got owner=%b rdy=%b exp 01/1", w4_arb_owner, w4_cpu_ready);
        end
        next_cycle();
        mem_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (w4_arb_owner !== 2'b00) begin
            failures++;
            $display("FAIL starve_gap1 got owner=%b exp 00", w4_arb_owner);
        end
        next_cycle();                       // IDLE, wait_cnt 3 -> CPU again
        next_cycle();
        mem_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (w4_arb_owner !== 2'b01) begin
            failures++;
            $display("FAIL starve_cpu2 got owner=%b exp 01", w4_arb_owner);
        end
        next_cycle();
        mem_ready = 1'b0;
        next_cycle();                       // IDLE, wait_cnt 6 -> DMA for MAX_WAIT=4
        next_cycle();
        @(negedge clk);
        checks++;
        if (w4_arb_owner !== 2'b10) begin
            failures++;
            $display("FAIL starve_dma_grant got owner=%b exp 10", w4_arb_owner);
        end
        checks++;
        if (dut4.wait_cnt !== 8'd0) begin
            failures++;
            $display("FAIL starve_wait_clear got=%0d exp=0", dut4.wait_cnt);
        end
        checks++;
        if (arb_owner !== 2'b01) begin
            failures++;
            $display("FAIL starve_mw16_cpu got owner=%b exp 01", arb_owner);
        end
        idle_inputs();
        next_cycle();
        next_cycle();
    endtask

    task automatic test_stall_count;
        logic [31:0] exp_stall;
`ifdef MEM_ARB_STATS_EN
        exp_stall = 32'd7;
`else
        exp_stall = 32'd0;
`endif
        do_reset();
        @(negedge clk);
        checks++;
        if (dma_stall_cnt !== 32'd0) begin
            failures++;
            $display("FAIL stall_reset got=%0d exp=0", dma_stall_cnt);
        end
        next_cycle();
        cpu_req = 1'b1; dma_req = 1'b1;
        next_cycle();                       // IDLE -> CPU
        next_cycle();
        next_cycle();
        next_cycle();
        mem_ready = 1'b1;                   // 4th GNT_CPU cycle completes
        next_cycle();
        mem_ready = 1'b0; cpu_req = 1'b0;
        next_cycle();                       // GAP
        next_cycle();                       // IDLE -> DMA
        @(negedge clk);
        checks++;
        if (arb_owner !== 2'b10 || dma_stall_cnt !== exp_stall) begin
            failures++;
            $display("FAIL stall_count got owner=%b cnt=%0d exp 10/%0d", arb_owner, dma_stall_cnt, exp_stall);
        end
        mem_ready = 1'b1;
        next_cycle();
        dma_req = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (dma_stall_cnt !== exp_stall) begin
            failures++;
            $display("FAIL stall_hold got=%0d exp=%0d", dma_stall_cnt, exp_stall);
        end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_reset_mid_transfer;
        do_reset();
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h80;
        next_cycle();
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1 || arb_owner !== 2'b10) begin
            failures++;
            $display("FAIL rst_mid_pre got req=%b owner=%b exp 1/10", mem_req, arb_owner);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || arb_owner !== 2'b00 || dma_ready !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_drop got req=%b owner=%b rdy=%b exp 0/00/0", mem_req, arb_owner, dma_ready);
        end
        repeat (2) @(posedge clk);
        #1;
        idle_inputs();
        rst_n = 1'b1;
        next_cycle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        idle_inputs();
        test_reset();
        test_cpu_read();
        test_same_cycle();
        test_dma_write();
        test_abort();
        test_starvation();
        test_stall_count();
        test_reset_mid_transfer();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
